// File: rtl/svk_apb_rtl_pkg.sv
// Shared types and helpers for the APB completer memory: FSM states, response
// codes and byte-offset to word-index conversion.
package svk_apb_rtl_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } svk_apb_slv_state_e;

  localparam logic SVK_APB_RESP_OKAY = 1'b0;
  localparam logic SVK_APB_RESP_ERR  = 1'b1;

  function automatic logic [31:0] svk_apb_word_idx(input logic [31:0] byte_off);
    return {2'b00, byte_off[31:2]};
  endfunction

endpackage

// File: rtl/svk_apb_if.sv
// APB3/APB4 bus bundle; the master drives the request, the slave the response.
interface svk_apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [3:0]            pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/svk_apb_slave_ram.sv
// Word storage behind the APB completer: synchronous byte-enabled write,
// asynchronous read, contents survive reset.
module svk_apb_slave_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/svk_apb_slave_mem.sv
// APB completer backed by word RAM: programmable wait states, byte strobes,
// PSLVERR on out-of-range or misaligned addresses, sticky protocol-error flag.
module svk_apb_slave_mem
  import svk_apb_rtl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic       pclk,
  input  logic       presetn,
  svk_apb_if.slave   apb,
  input  logic [3:0] wait_cfg,
  output logic       proto_err
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("svk_apb_slave_mem supports DATA_WIDTH=32 only");
  end

  localparam int                  IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);

  svk_apb_slv_state_e state;
  logic [3:0]         cnt;
  logic               pready_q;
  logic               pslverr_q;
  logic [31:0]        prdata_q;
  logic               err_q;

  logic               pwrite_q;
  logic [3:0]         pstrb_q;
  logic [31:0]        pwdata_q;
  logic [IDX_W-1:0]   idx_q;

  logic [ADDR_WIDTH-1:0] byte_off;
  logic [31:0]           word_full;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic [IDX_W-1:0]      rd_idx;
  logic [31:0]           ram_rdata;
  logic                  ram_we;
  logic                  setup;
  logic                  unused_bits;

  assign byte_off  = apb.paddr - BASE_ADDR;
  assign word_full = svk_apb_word_idx(32'(byte_off));
  assign dec_idx   = word_full[IDX_W-1:0];
  assign dec_err   = (apb.paddr < BASE_ADDR) || ({1'b0, byte_off} >= BYTE_LIMIT) ||
                     (apb.paddr[1:0] != 2'b00);
  assign setup     = apb.psel && !apb.penable;

  // The read port follows the live address in IDLE so a zero-wait read has data
  // ready on the setup edge; afterwards it follows the latched index.
  assign rd_idx = (state == IDLE) ? dec_idx : idx_q;
  assign ram_we = (state == ACCESS) && apb.psel && apb.penable && pready_q &&
                  pwrite_q && !err_q;

  assign unused_bits = ^{apb.pprot, word_full[31:IDX_W]};

  svk_apb_slave_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk   (pclk),
    .we    (ram_we),
    .be    (pstrb_q),
    .waddr (idx_q),
    .wdata (pwdata_q),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  // Request capture on the setup edge; data only, no reset needed.
  always_ff @(posedge pclk) begin
    if (state == IDLE && setup) begin
      pwrite_q <= apb.pwrite;
      pstrb_q  <= apb.pstrb;
      pwdata_q <= apb.pwdata;
      idx_q    <= dec_idx;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= SVK_APB_RESP_OKAY;
      prdata_q  <= '0;
      err_q     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= SVK_APB_RESP_OKAY;
          prdata_q  <= '0;
          if (setup) begin
            state <= ACCESS;
            cnt   <= wait_cfg;
            err_q <= dec_err;
            if (wait_cfg == 4'd0) begin
              pready_q  <= 1'b1;
              pslverr_q <= dec_err ? SVK_APB_RESP_ERR : SVK_APB_RESP_OKAY;
              prdata_q  <= (!apb.pwrite && !dec_err) ? ram_rdata : '0;
            end
          end
        end
        ACCESS: begin
          if (!apb.psel) begin
            proto_err <= 1'b1;
            pready_q  <= 1'b0;
            pslverr_q <= SVK_APB_RESP_OKAY;
            prdata_q  <= '0;
            state     <= IDLE;
          end else if (apb.penable) begin
            if (pready_q) begin
              pready_q  <= 1'b0;
              pslverr_q <= SVK_APB_RESP_OKAY;
              prdata_q  <= '0;
              state     <= IDLE;
            end else begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) begin
                pready_q  <= 1'b1;
                pslverr_q <= err_q ? SVK_APB_RESP_ERR : SVK_APB_RESP_OKAY;
                prdata_q  <= (!pwrite_q && !err_q) ? ram_rdata : '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule

// File: tb/tb_svk_apb_slave_mem.sv
// Scoreboard bench for svk_apb_slave_mem: directed scenarios plus randomized
// transfers checked against an array-based memory model.
module tb_svk_apb_slave_mem;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        rd;
    int          wt;
  } exp_t;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic [3:0] wait_cfg = 4'd0;
  logic       proto_err;

  svk_apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  svk_apb_slave_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (bus),
    .wait_cfg  (wait_cfg),
    .proto_err (proto_err)
  );

  always #5 pclk = ~pclk;

  int          checks = 0;
  int          errors = 0;
  int          acc_cycles = 0;
  exp_t        sb_q[$];
  logic [31:0] model [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a < BASE) || ((a - BASE) >= 32'(DEPTH * 4)) || (a[1:0] != 2'b00);
  endfunction

  // Model: plain array of words, byte-lane merge on write.
  task automatic model_expect(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int w, output exp_t e);
    int idx;
    e.err = addr_bad(addr);
    e.rd  = !wr;
    e.wt  = w;
    e.data = 32'h0;
    idx = int'((addr - BASE) / 4);
    if (!e.err) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) model[idx][8*i +: 8] = data[8*i +: 8];
      end else begin
        e.data = model[idx];
      end
    end
  endtask

  task automatic drive_setup(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    bus.pstrb   = strb;
    bus.pprot   = 3'($urandom);
    wait_cfg    = 4'(w);
  endtask

  task automatic finish_access(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      if (bus.pready) done = 1'b1;
      @(posedge pclk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: pready never rose, got 0, expected 1", name);
    end
    bus.penable = 1'b0;
  endtask

  // Full transfer; use_exp overrides the model's expectation with a fixed constant.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int w, input bit use_exp = 1'b0,
                      input logic [31:0] exp_data = 32'h0, input bit exp_err = 1'b0);
    exp_t e;
    model_expect(wr, addr, data, strb, w, e);
    if (use_exp) begin
      e.data = exp_data;
      e.err  = exp_err;
    end
    sb_q.push_back(e);
    drive_setup(wr, addr, data, strb, w);
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    wait_cfg    = 4'($urandom);
    finish_access("xfer");
  endtask

  task automatic idle(input int n);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  // Monitor: setup cycles must see a quiet response; completions are scored.
  always @(negedge pclk) begin
    exp_t e;
    if (!presetn) begin
      acc_cycles = 0;
    end else if (bus.psel && !bus.penable) begin
      check("setup_prdata", bus.prdata, 32'h0);
      check("setup_pready", 32'(bus.pready), 32'h0);
      acc_cycles = 0;
    end else if (bus.psel && bus.penable) begin
      acc_cycles++;
      if (bus.pready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got pready=1, expected no transfer pending");
        end else begin
          e = sb_q.pop_front();
          check("latency", 32'(acc_cycles), 32'(e.wt + 1));
          check("pslverr", 32'(bus.pslverr), 32'(e.err));
          if (e.rd || e.err) check("prdata", bus.prdata, e.data);
        end
      end
    end else begin
      acc_cycles = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   r;
    logic [31:0] a;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
    bus.pwdata = '0; bus.pstrb = 4'h0; bus.pprot = 3'h0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready", 32'(bus.pready), 32'h0);
    check("rst_pslverr", 32'(bus.pslverr), 32'h0);
    check("rst_prdata", bus.prdata, 32'h0);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(1);

    for (int i = 0; i < DEPTH; i++) xfer(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0);
    idle(1);

    // 1: zero wait write then read
    xfer(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 1'b1, 32'hDEADBEEF, 1'b0);
    idle(1);
    // 2: three wait states
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 3, 1'b1, 32'hDEADBEEF, 1'b0);
    idle(1);
    // 3: partial strobes
    xfer(1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, 1);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 1'b1, 32'hDE22BE44, 1'b0);
    xfer(1'b1, BASE + 32'h10, 32'h55667788, 4'b0000, 2);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 1'b1, 32'hDE22BE44, 1'b0);
    idle(1);
    // 4: decode errors
    xfer(1'b1, BASE + 32'(DEPTH * 4), 32'h12345678, 4'hF, 2, 1'b1, 32'h0, 1'b1);
    xfer(1'b0, BASE + 32'h13, 32'h0, 4'hF, 0, 1'b1, 32'h0, 1'b1);
    xfer(1'b0, BASE - 32'h4, 32'h0, 4'hF, 1, 1'b1, 32'h0, 1'b1);
    xfer(1'b1, BASE + 32'h12, 32'hFFFFFFFF, 4'hF, 0, 1'b1, 32'h0, 1'b1);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 1'b1, 32'hDE22BE44, 1'b0);
    idle(1);

    // 5: psel dropped during wait states
    drive_setup(1'b1, BASE + 32'h10, 32'hCAFEF00D, 4'hF, 5);
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(negedge pclk);
    check("abort_pready", 32'(bus.pready), 32'h0);
    @(posedge pclk); #1;
    idle(1);
    @(negedge pclk);
    check("abort_proto_err", 32'(proto_err), 32'h1);
    @(posedge pclk); #1;
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1, 1'b1, 32'hDE22BE44, 1'b0);
    idle(1);
    check("proto_err_sticky", 32'(proto_err), 32'h1);

    // 6: reset while a read response is being presented
    e.data = 32'hDE22BE44; e.err = 1'b0; e.rd = 1'b1; e.wt = 0;
    sb_q.push_back(e);
    drive_setup(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0);
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(negedge pclk); #2;
    presetn = 1'b0;
    #1;
    check("mid_rst_pready", 32'(bus.pready), 32'h0);
    check("mid_rst_pslverr", 32'(bus.pslverr), 32'h0);
    check("mid_rst_prdata", bus.prdata, 32'h0);
    check("mid_rst_proto_err", 32'(proto_err), 32'h0);
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(1);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 2, 1'b1, 32'hDE22BE44, 1'b0);
    for (int i = 0; i < 4; i++)
      xfer(1'b0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0, 4'hF, $urandom_range(0, 3));
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      else if (r == 8) a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
      else             a = BASE - 32'(4 * $urandom_range(1, 16));
      xfer(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    idle(3);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
